// File: rtl/pixel_readout_sequencer.sv
// Readout sequencer: walks rows and column groups of the pixel array and streams beats downstream.
// Optional stall timeout in HOLD is built when READOUT_TIMEOUT_EN is defined.
module pixel_readout_sequencer #(
    parameter int unsigned WIDTH                  = 2,
    parameter int unsigned HEIGHT                 = 2,
    parameter int unsigned OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int unsigned BIT_DEPTH              = 8,
    parameter int unsigned TIMEOUT_CYCLES         = 255,
    localparam int unsigned GROUPS = (WIDTH + OUTPUT_BUS_PIXEL_WIDTH - 1) / OUTPUT_BUS_PIXEL_WIDTH,
    localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int unsigned BW     = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH
) (
    input  logic              SYSTEM_CLK,
    input  logic              SYSTEM_RESET,
    input  logic              READOUT_START,
    input  logic [BW-1:0]     PIXEL_DATA_IN,
    input  logic              OUT_READY,
    output logic              READ_RESET,
    output logic [HEIGHT-1:0] ROW_SELECT,
    output logic [GW-1:0]     COL_GROUP,
    output logic [BW-1:0]     DATA_OUT,
    output logic              OUT_VALID,
    output logic              FRAME_START,
    output logic              FRAME_END,
    output logic              BUSY,
    output logic              READOUT_DONE,
    output logic              TIMEOUT_ERR
);

    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RDRST, S_ADDR, S_HOLD, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [GW-1:0]       grp_q, grp_d;
    logic [BW-1:0]       data_q, pix_masked;
    logic                valid_q, fs_q, fe_q, busy_q, done_q, rr_q;
    logic [HEIGHT-1:0]   rowsel_q;
    logic [GW-1:0]       col_q;
    logic                last_beat, addressed_d;

`ifdef READOUT_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0]       stall_q, stall_d;
    logic                err_q, err_d;
`endif

    assign last_beat   = (row_q == RW'(HEIGHT - 1)) && (grp_q == GW'(GROUPS - 1));
    assign addressed_d = (state_d == S_ADDR) || (state_d == S_HOLD);

    // Zero the lanes of a partial last group that lie beyond the array width
    always_comb begin
        pix_masked = PIXEL_DATA_IN;
        for (int unsigned k = 0; k < OUTPUT_BUS_PIXEL_WIDTH; k++) begin
            if ((32'(grp_q) * OUTPUT_BUS_PIXEL_WIDTH + k) >= WIDTH) begin
                pix_masked[k*BIT_DEPTH +: BIT_DEPTH] = '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        grp_d   = grp_q;
`ifdef READOUT_TIMEOUT_EN
        stall_d = stall_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (READOUT_START) begin
                    state_d = S_RDRST;
                    row_d   = '0;
                    grp_d   = '0;
`ifdef READOUT_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_RDRST: state_d = S_ADDR;
            S_ADDR:  state_d = S_HOLD;
            S_HOLD: begin
                if (OUT_READY) begin
`ifdef READOUT_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADDR;
                        if (grp_q == GW'(GROUPS - 1)) begin
                            grp_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            grp_d = grp_q + GW'(1);
                        end
                    end
                end
`ifdef READOUT_TIMEOUT_EN
                else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_DONE;
                    stall_d = '0;
                    err_d   = 1'b1;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state they describe
    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            grp_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            fe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rr_q     <= 1'b0;
            rowsel_q <= '0;
            col_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            grp_q    <= grp_d;
            if (state_q == S_ADDR) begin
                data_q <= pix_masked;
            end
            valid_q  <= (state_d == S_HOLD);
            fs_q     <= (state_d == S_HOLD) && (row_d == '0) && (grp_d == '0);
            fe_q     <= (state_d == S_HOLD) && (row_d == RW'(HEIGHT - 1)) && (grp_d == GW'(GROUPS - 1));
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DONE);
            rr_q     <= (state_d == S_RDRST);
            rowsel_q <= addressed_d ? (HEIGHT'(1) << row_d) : '0;
            col_q    <= addressed_d ? grp_d : '0;
        end
    end

`ifdef READOUT_TIMEOUT_EN
    always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
    assign TIMEOUT_ERR = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign TIMEOUT_ERR    = 1'b0;
`endif

    assign READ_RESET   = rr_q;
    assign ROW_SELECT   = rowsel_q;
    assign COL_GROUP    = col_q;
    assign DATA_OUT     = data_q;
    assign OUT_VALID    = valid_q;
    assign FRAME_START  = fs_q;
    assign FRAME_END    = fe_q;
    assign BUSY         = busy_q;
    assign READOUT_DONE = done_q;

endmodule
